// File: rtl/inst_encoder_loader_pkg.sv
// inst_encoder_loader_pkg: opcode constants, op-class codes and loader FSM states.
package inst_encoder_loader_pkg;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   typedef enum logic [2:0] {
      CLS_BRANCH = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_IMM    = 3'd3,
      CLS_REG    = 3'd4,
      CLS_END    = 3'd7
   } op_class_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_FINISH} state_e;
endpackage

// File: rtl/inst_field_packer.sv
// inst_field_packer: packs instruction fields into an RV32I word and flags illegal combinations.
module inst_field_packer
   import inst_encoder_loader_pkg::*;
(
   input  logic [2:0]  op_class,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);
   logic [31:0] raw;
   logic        imm12_ok;
   logic        shift;
   logic        f3_word;
   assign imm12_ok = imm[12] == imm[11];
   assign shift    = funct3[1:0] == 2'b01;
   assign f3_word  = funct3 == 3'b010;
   // Unknown classes fall through as illegal; the end marker never reaches memory.
   always_comb begin
      raw     = NOP;
      illegal = 1'b1;
      case (op_class)
         CLS_BRANCH: begin
            raw     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            illegal = funct3[2:1] == 2'b01 || imm[0];
         end
         CLS_LOAD: begin
            raw     = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            illegal = !f3_word || !imm12_ok;
         end
         CLS_STORE: begin
            raw     = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            illegal = !f3_word || !imm12_ok;
         end
         CLS_IMM: begin
            raw     = shift ? {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM}
                            : {imm[11:0], rs1, funct3, rd, OP_IMM};
            illegal = shift ? (|imm[12:5] || (!funct3[2] && alt)) : !imm12_ok;
         end
         CLS_REG: begin
            raw     = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_REG};
            illegal = alt && funct3 != 3'b000 && funct3 != 3'b101;
         end
         default: ;
      endcase
   end
   assign word = illegal ? NOP : raw;
endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: accepts instruction field transfers and writes encoded words
// to instruction memory, one word per acknowledged write.
module inst_encoder_loader
   import inst_encoder_loader_pkg::*;
#(
   parameter int MAX_INST = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic        op_valid_i,
   output logic        op_ready_o,
   input  logic [2:0]  op_class_i,
   input  logic [2:0]  funct3_i,
   input  logic        alt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [12:0] imm_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] count_o
);
   state_e      state, state_nx;
   logic [31:0] word;
   logic        illegal;
   logic        xfer;
   logic        end_op;
   logic        full;
   inst_field_packer u_packer (
      .op_class (op_class_i),
      .funct3   (funct3_i),
      .alt      (alt_i),
      .rd       (rd_i),
      .rs1      (rs1_i),
      .rs2      (rs2_i),
      .imm      (imm_i),
      .word     (word),
      .illegal  (illegal)
   );
   assign xfer   = op_valid_i && op_ready_o;
   assign end_op = op_class_i == CLS_END;
   assign full   = count_o == 16'(MAX_INST);
   assign busy_o = state != ST_IDLE;
   always_comb begin
      state_nx   = state;
      op_ready_o = 1'b0;
      mem_we_o   = 1'b0;
      done_o     = 1'b0;
      case (state)
         ST_IDLE:   state_nx = start_i ? ST_ACCEPT : ST_IDLE;
         ST_ACCEPT: begin
            op_ready_o = 1'b1;
            if (op_valid_i) state_nx = (end_op || full) ? ST_FINISH : ST_WRITE;
         end
         ST_WRITE: begin
            mem_we_o = 1'b1;
            if (mem_ack_i) state_nx = ST_ACCEPT;
         end
         ST_FINISH: begin
            done_o   = 1'b1;
            state_nx = ST_IDLE;
         end
         default:   state_nx = ST_IDLE;
      endcase
   end
   // A transfer past the word limit only raises err; the FSM heads to FINISH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         count_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && start_i) begin
            mem_addr_o <= {base_addr_i[31:2], 2'b00};
            count_o    <= '0;
            err_o      <= 1'b0;
         end
         if (xfer && !end_op) begin
            if (full) err_o <= 1'b1;
            else begin
               mem_wdata_o <= word;
               err_o       <= err_o | illegal;
            end
         end
         if (mem_we_o && mem_ack_i) begin
            mem_addr_o <= mem_addr_o + 32'd4;
            count_o    <= count_o + 16'd1;
         end
      end
   end
endmodule

// File: doc/inst_encoder_loader.md
INST_ENCODER_LOADER -- requirements
Module: inst_encoder_loader

Interface
REQ-001 SHALL have parameter MAX_INST, default 1024: maximum instructions written per program load.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1: begin a program load at base_addr_i.
REQ-005 SHALL have port base_addr_i, input, 32: byte address of the first word; bits [1:0] ignored.
REQ-006 SHALL have ports op_valid_i (input, 1) and op_ready_o (output, 1): field-transfer handshake.
REQ-007 SHALL have port op_class_i, input, 3: 0 branch, 1 load, 2 store, 3 immediate, 4 register, 7 end-of-program; 5 and 6 illegal.
REQ-008 SHALL have ports funct3_i (input, 3) and alt_i (input, 1, maps to funct7[5]).
REQ-009 SHALL have ports rd_i, rs1_i and rs2_i, each input, 5.
REQ-010 SHALL have port imm_i, input, 13: signed immediate or branch byte offset.
REQ-011 SHALL have ports mem_we_o (output, 1), mem_addr_o (output, 32), mem_wdata_o (output, 32) and mem_ack_i (input, 1): instruction-memory write port.
REQ-012 SHALL have ports busy_o (output, 1), done_o (output, 1 pulse), err_o (output, 1, sticky) and count_o (output, 16, words written).

Function
REQ-013 SHALL implement FSM states IDLE, ACCEPT, WRITE and FINISH.
REQ-014 IDLE SHALL go to ACCEPT on start_i: load base_addr_i into the address counter and clear count_o and err_o.
REQ-015 ACCEPT SHALL assert op_ready_o; a transfer occurs when op_valid_i and op_ready_o are both high.
REQ-016 A transfer with class 0-6 SHALL register the encoded word and go to WRITE; mem_we_o SHALL rise the next cycle, giving 1-cycle latency.
REQ-017 A transfer with class 7 SHALL go to FINISH without a memory write.
REQ-018 WRITE SHALL hold mem_we_o, mem_addr_o and mem_wdata_o stable until mem_ack_i is sampled high.
REQ-019 On that ack the module SHALL increment mem_addr_o by 4 and count_o by 1, then return to ACCEPT; op_ready_o SHALL stay low throughout WRITE.
REQ-020 FINISH SHALL pulse done_o for exactly one cycle and then go to IDLE.
REQ-021 busy_o SHALL be high in every state except IDLE; start_i while busy SHALL be ignored.
REQ-022 Opcodes SHALL be branch 1100011, load 0000011, store 0100011, immediate 0010011 and register 0110011, using standard RV32I B/I/S/I/R field placement.
REQ-023 Register class: funct7 = {1'b0, alt_i, 5'b0}.
REQ-024 Immediate shift class (funct3 001/101): bits [31:25] = {1'b0, alt_i, 5'b0} and shamt = imm_i[4:0].
REQ-025 Illegal combinations SHALL be:
- class 5/6;
- branch funct3 010/011, or imm_i[0]=1;
- load/store funct3 other than 010;
- I/S immediate outside signed 12-bit range;
- shift with imm_i[12:5] != 0;
- shift left with alt_i=1;
- register class with alt_i=1 and funct3 not 000/101;
- non-shift immediate ops ignore alt_i.
REQ-026 On an illegal transfer the module SHALL write NOP 0x00000013 instead of the encoded word and set err_o, which stays high until the next start.
REQ-027 When count_o reaches MAX_INST, the next transfer SHALL set err_o and go to FINISH with no write.
REQ-028 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-029 rst_i SHALL immediately force IDLE and drive all outputs to 0, including mid-WRITE; the interrupted write is abandoned and no done_o is produced.
REQ-030 After reset deassertion, no write SHALL occur until a new start_i.

Structure
REQ-031 A shared package SHALL hold the five opcode constants, op-class codes, the NOP constant and the FSM state enum.
REQ-032 Encoding and legality checking SHALL be a combinational sub-module inst_field_packer producing {word, illegal}; the top holds only the FSM, counters and registers.

Verification
REQ-033 start, base 0x100; addi rd1 rs1 0 imm 5 -> write 0x00500093 at 0x100, count 1.
REQ-034 Register add rd3 rs1 1 rs2 2 then sub (alt=1) -> 0x002081B3 at 0x100, then 0x402081B3 at 0x104.
REQ-035 lw rd5 rs1 2 imm 8, then sw rs2 5 rs1 2 imm 12, then beq rs1 1 rs2 2 imm -4, then srai rd4 rs1 4 imm 3 alt=1 -> 0x00812283, 0x00512623, 0xFE208EE3, 0x40325213.
REQ-036 mem_ack_i held low 5 cycles -> mem_we_o and mem_addr_o/mem_wdata_o stable 5 cycles, op_ready_o low; class 7 -> done_o single pulse, busy_o falls.
REQ-037 Load with funct3 000 -> NOP 0x00000013 written and err_o high; MAX_INST=2 with a third op -> err_o, no third write, done_o.
REQ-038 rst_i asserted during WRITE -> mem_we_o low immediately, state IDLE, no done_o, count_o 0.
